// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between the adder result stream, the accumulator and the result sink.
//
//   in_valid  / in_ready  : input beat handshake
//   in_sum    [N:0]       : adder result, bit N is the adder carry out
//   in_last               : beat closes the current frame
//   out_valid / out_ready : frame result handshake
//   out_acc   [ACC_W-1:0] : frame total modulo 2^ACC_W
//   out_count [15:0]      : beats in frame, saturating at 65535
//   out_ovf               : some accumulation in the frame carried out of ACC_W bits
//
// master: the environment (source of beats and sink of results).
// slave : the accumulator block.
interface adder_result_accumulator_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [N:0]       in_sum;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [15:0]      out_count;
  logic             out_ovf;

  modport master (
    output in_valid,
    output in_sum,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_acc,
    input  out_count,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_sum,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_acc,
    output out_count,
    output out_ovf
  );
endinterface

// File: rtl/adder_result_accumulator.sv
// Accumulates a stream of N+1-bit adder results into an ACC_W-bit running total.
// A beat flagged in_last closes the frame: total, beat count and sticky overflow are
// registered onto the result port and held until the sink takes them. While a result
// is held no further beats are accepted.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset; discards partial sums and pending results
//   bus  : slave side of adder_result_accumulator_if (beat input, frame result output)
module adder_result_accumulator #(
  parameter int unsigned N     = 32,
  parameter int unsigned ACC_W = 40
) (
  input logic                      clk,
  input logic                      rst,
  adder_result_accumulator_if.slave bus
);

  // Elaboration-time parameter legality.
  if (N < 1 || N > 32) begin : g_bad_n
    $error("adder_result_accumulator: N must be in 1..32");
  end
  if (ACC_W < N + 1) begin : g_bad_acc_w
    $error("adder_result_accumulator: ACC_W must be at least N+1");
  end

  localparam logic [15:0] CountMax = 16'hFFFF;

  typedef enum logic [0:0] {
    StAccum,
    StHold
  } state_e;

  state_e           state_q, state_d;

  // Running frame state.
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      count_q, count_d;
  logic             ovf_q, ovf_d;

  // Registered frame result.
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [15:0]      out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             in_ready;
  logic             in_fire;
  logic [ACC_W:0]   acc_sum;   // one extra bit captures the carry out of the ACC_W add
  logic [ACC_W-1:0] acc_upd;
  logic [15:0]      count_upd;
  logic             ovf_upd;

  // Ready depends on state and reset only, so a source may wait on it without a
  // combinational loop through in_valid.
  assign in_ready = (state_q == StAccum) && !rst;
  assign in_fire  = bus.in_valid && in_ready;

  // Zero-extend the beat to ACC_W+1 bits before adding.
  assign acc_sum   = {1'b0, acc_q} + {{(ACC_W - N){1'b0}}, bus.in_sum};
  assign acc_upd   = acc_sum[ACC_W-1:0];
  assign ovf_upd   = ovf_q | acc_sum[ACC_W];
  assign count_upd = (count_q == CountMax) ? count_q : count_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      StAccum: begin
        if (in_fire) begin
          if (bus.in_last) begin
            // Publish the totals including this beat and start the next frame clean.
            out_acc_d   = acc_upd;
            out_count_d = count_upd;
            out_ovf_d   = ovf_upd;
            out_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            state_d     = StHold;
          end else begin
            acc_d   = acc_upd;
            count_d = count_upd;
            ovf_d   = ovf_upd;
          end
        end
      end
      StHold: begin
        // Result fields are left as-is after the handshake; only valid drops.
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAccum;
        end
      end
      default: begin
        state_d = StAccum;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: directed reset, basic, maximal-operand,
// backpressure and count-saturation frames plus randomized frames, all scored
// against a frame-level arithmetic model.
module tb_adder_result_accumulator;

  localparam int unsigned N     = 32;
  localparam int unsigned ACC_W = 40;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  adder_result_accumulator_if #(.N(N), .ACC_W(ACC_W)) bus ();

  adder_result_accumulator #(.N(N), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level model: true (unbounded) sum per frame; overflow is simply the true
  // sum reaching 2^ACC_W, since every beat is non-negative.
  typedef struct {
    logic [39:0] acc;
    logic [15:0] cnt;
    logic        ovf;
  } frame_t;

  frame_t          exp_q[$];
  longint unsigned m_tot    = 0;
  int              m_beats  = 0;
  int              frames_sent = 0;
  int              frames_seen = 0;

  function automatic void model_accept(input logic [32:0] s, input logic last);
    frame_t f;
    m_tot += 64'(s);
    m_beats++;
    if (last) begin
      f.acc = m_tot[39:0];
      f.cnt = (m_beats > 65535) ? 16'hFFFF : 16'(m_beats);
      f.ovf = (m_tot >= (64'd1 << ACC_W));
      exp_q.push_back(f);
      frames_sent++;
      m_tot   = 0;
      m_beats = 0;
    end
  endfunction

  // out_ready policy: 0 = low, 1 = high, 2 = random. Applied 2 time units after each edge.
  int ordy_mode = 1;
  always @(posedge clk) begin
    #2;
    case (ordy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard: every result handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      frame_t e;
      frames_seen++;
      check_eq("frame_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("sb_acc", 64'(bus.out_acc), 64'(e.acc));
        check_eq("sb_count", 64'(bus.out_count), 64'(e.cnt));
        check_eq("sb_ovf", 64'(bus.out_ovf), 64'(e.ovf));
      end
    end
  end

  // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send_beat(input logic [32:0] s, input logic last);
    bit rdy;
    bit done;
    int waited;
    waited       = 0;
    done         = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    bus.in_last  = last;
    while (!done) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        model_accept(s, last);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          check_eq("accept_timeout", 64'(waited), 64'd0);
          done = 1'b1;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_out_acc"}, 64'(bus.out_acc), 64'd0);
    check_eq({tag, "_out_count"}, 64'(bus.out_count), 64'd0);
    check_eq({tag, "_out_ovf"}, 64'(bus.out_ovf), 64'd0);
  endtask

  localparam logic [32:0] MaxBeat = 33'h1_FFFF_FFFE;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-frame after 3 beats: partial frame must vanish.
    send_beat(33'd100, 1'b0);
    send_beat(33'd200, 1'b0);
    send_beat(33'd300, 1'b0);
    #2 rst = 1'b1;
    #1 check_idle_outputs("midreset");
    m_tot   = 0;
    m_beats = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    send_beat(33'd5, 1'b1);
    check_eq("rst_frame_valid", 64'(bus.out_valid), 64'd1);
    check_eq("rst_frame_acc", 64'(bus.out_acc), 64'd5);
    check_eq("rst_frame_count", 64'(bus.out_count), 64'd1);
    check_eq("rst_frame_ovf", 64'(bus.out_ovf), 64'd0);

    // Basic frame, out_valid for exactly one cycle.
    send_beat(33'd10, 1'b0);
    send_beat(33'd20, 1'b0);
    send_beat(33'd30, 1'b1);
    check_eq("basic_valid", 64'(bus.out_valid), 64'd1);
    check_eq("basic_acc", 64'(bus.out_acc), 64'd60);
    check_eq("basic_count", 64'(bus.out_count), 64'd3);
    check_eq("basic_ovf", 64'(bus.out_ovf), 64'd0);
    @(posedge clk);
    #1 check_eq("basic_valid_drop", 64'(bus.out_valid), 64'd0);

    // Maximal operands: 128 beats fit, 129 overflow.
    for (int i = 0; i < 128; i++) send_beat(MaxBeat, 1'(i == 127));
    check_eq("max128_acc", 64'(bus.out_acc), 64'h00FF_FFFF_FF00);
    check_eq("max128_ovf", 64'(bus.out_ovf), 64'd0);
    check_eq("max128_count", 64'(bus.out_count), 64'd128);
    for (int i = 0; i < 129; i++) send_beat(MaxBeat, 1'(i == 128));
    check_eq("max129_acc", 64'(bus.out_acc), 64'h0001_FFFF_FEFE);
    check_eq("max129_ovf", 64'(bus.out_ovf), 64'd1);
    check_eq("max129_count", 64'(bus.out_count), 64'd129);

    // Backpressure: result held 5 cycles with in_valid high, then released.
    @(posedge clk);
    #1 ordy_mode = 0;
    send_beat(33'd1000, 1'b0);
    send_beat(33'd2000, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_sum   = 33'd7;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("bp_out_acc", 64'(bus.out_acc), 64'd3000);
      check_eq("bp_out_count", 64'(bus.out_count), 64'd2);
      check_eq("bp_out_ovf", 64'(bus.out_ovf), 64'd0);
    end
    @(posedge clk);
    #1 ordy_mode = 1;
    @(negedge clk);
    check_eq("bp_release_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check_eq("bp_next_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    model_accept(33'd7, 1'b1);
    bus.in_valid = 1'b0;
    check_eq("bp_next_valid", 64'(bus.out_valid), 64'd1);
    check_eq("bp_next_acc", 64'(bus.out_acc), 64'd7);

    // Random frames with random input gaps and random out_ready.
    ordy_mode = 2;
    for (int f = 0; f < 100; f++) begin
      int nb;
      nb = $urandom_range(1, 8);
      for (int j = 0; j < nb; j++) begin
        logic [31:0] a;
        logic [31:0] b;
        int          gap;
        a = $urandom;
        b = $urandom;
        send_beat({1'b0, a} + {1'b0, b}, 1'(j == nb - 1));
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end

    // Count saturation.
    ordy_mode = 1;
    for (int i = 0; i < 65536; i++) send_beat(33'd0, 1'b0);
    send_beat(33'd0, 1'b1);
    check_eq("sat_count", 64'(bus.out_count), 64'd65535);
    check_eq("sat_acc", 64'(bus.out_acc), 64'd0);
    check_eq("sat_ovf", 64'(bus.out_ovf), 64'd0);

    repeat (10) @(posedge clk);
    #1;
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    check_eq("frames_seen", 64'(frames_seen), 64'(frames_sent));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_result_accumulator.md
# adder_result_accumulator

Downstream consumer of the N-bit full adder's result stream. Each N+1-bit sum (carry as MSB) is accepted over a valid/ready handshake and added into a wide running accumulator. A frame ends on a beat flagged `in_last`. The frame total, beat count and sticky overflow flag are then held on a registered output until the downstream sink takes them.

## Interface
- `N`, 32, adder operand width; legal range 1..32; any other value is an elaboration error.
- `ACC_W`, 40, accumulator width; must be ≥ N+1.
- `clk` input, 1: single clock; all state on rising edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `in_valid` input, 1: `in_sum`/`in_last` valid.
- `in_ready` output, 1: block accepts a beat this cycle.
- `in_sum` input, N+1: adder result, bit N = carry out.
- `in_last` input, 1: beat is last of frame.
- `out_valid` output, 1: frame result held.
- `out_ready` input, 1: sink accepts result.
- `out_acc` output, ACC_W: frame total modulo 2^ACC_W.
- `out_count` output, 16: beats in frame, saturating.
- `out_ovf` output, 1: sticky, set if any accumulation carried out of ACC_W.

## Operation
- States:
  - ACCUM: collecting beats.
  - HOLD: result presented.
- Reset values, applied asynchronously while `rst`=1:
  - state=ACCUM.
  - internal acc=0, count=0, ovf=0.
  - `out_valid`=0, `out_acc`=0, `out_count`=0, `out_ovf`=0.
  - `in_ready`=0 while `rst` is high.
- `in_ready` = (state==ACCUM) && !rst. It is combinational from state only, never from `in_valid`.
- Input handshake fires when `in_valid` && `in_ready`. On fire:
  - acc ← acc + zero-extended `in_sum`, truncated to ACC_W bits.
  - ovf ← ovf | carry out of that ACC_W-bit add.
  - count ← count+1, saturating at 65535.
- Fire with `in_last`=0: stay in ACCUM.
- Fire with `in_last`=1:
  - `out_acc`, `out_count`, `out_ovf` are loaded with the updated values, including this beat.
  - `out_valid` ← 1; state → HOLD.
  - Internal acc/count/ovf are cleared to 0 in the same edge.
- HOLD:
  - `in_ready`=0.
  - Outputs stay stable while `out_valid`=1 and `out_ready`=0.
  - On `out_valid` && `out_ready`: `out_valid` ← 0, state → ACCUM.
  - `out_acc`/`out_count`/`out_ovf` keep their last values after the handshake; they are meaningful only while `out_valid`=1.
- `in_valid`=0 cycles in ACCUM: no state change.
- `in_sum` is ignored when no fire occurs.
- A single-beat frame (`in_last` on the first beat) is legal and gives count=1.
- No empty frames: a frame always contains ≥1 beat.
- Reset mid-frame or in HOLD: partial sums and any pending result are discarded. Nothing is emitted.

## Timing
- Accept throughput: 1 beat/cycle in ACCUM.
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` beat, i.e. it is visible the cycle after the handshake.
- Output handshake to next input acceptance: `in_ready` goes high the cycle after the `out_ready` handshake. There is no same-cycle bypass.
- Minimum frame period: beats + 1 cycle, given `out_ready` held high.
- Arithmetic:
  - Unsigned throughout.
  - Maximum single beat = 2^(N+1)−2 (both adder operands all-ones).
  - With N=32 and ACC_W=40, at least 128 maximum beats fit before overflow.
- After `rst` deasserts, the first edge may accept a beat if `in_valid`=1.

## Test plan
- **Reset:** assert `rst` mid-stream after 3 beats, release, then send a 1-beat frame with `in_sum`=5 → `out_acc`=5, `out_count`=1, `out_ovf`=0. No earlier frame is emitted; every output is 0 during reset.
- **Basic frame:** N=32, beats 10, 20, 30 (last on 30), `out_ready`=1 → `out_valid` for exactly one cycle; `out_acc`=60, `out_count`=3, `out_ovf`=0.
- **Maximal operands:** N=32, 128 beats of 0x1_FFFF_FFFE (result of all-ones + all-ones) → `out_acc`=0xFF_FFFF_FF00, `out_ovf`=0. The same frame with 129 beats → `out_ovf`=1, `out_acc`=(129·0x1FFFFFFFE) mod 2^40.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after the result appears, with `in_valid`=1 continuously → `in_ready`=0 and outputs stable throughout. When `out_ready` rises, the next frame's first beat is accepted one cycle later.
- **Random frames:** 100 random frames of 1–8 beats from random N-bit operand sums, with random `in_valid`/`out_ready` gaps → each `out_acc` matches a reference model sum mod 2^40, with no lost or duplicated beats.
- **Count saturation:** 65,537-beat frame of `in_sum`=0 → `out_count`=65535, `out_acc`=0.
